// File: rtl/peatonal.sv
// peatonal: pedestrian-crossing controller downstream of the semaforo vehicle light.
//
// It watches the vehicle lamps and a pedestrian push-button and drives the walk
// and dont_walk lamps. Walk is granted only inside a vehicle red phase, only
// when a request is latched, and only after a clearance delay. If two or more
// vehicle lamps are lit at once, the block latches a safe fault state.
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          asynchronous, active-low reset
//   red          vehicle red lamp
//   yellow       vehicle yellow lamp
//   green        vehicle green lamp
//   button       pedestrian push-button, synchronous level
//   walk         walk lamp
//   dont_walk    don't-walk lamp (flashes after the walk interval)
//   req_pending  pedestrian request latched and not yet served
//   fault        lamp-conflict fault, sticky until reset
module peatonal #(
    parameter int CLEAR_TICKS = 2,
    parameter int WALK_TICKS  = 8,
    parameter int FLASH_HALF  = 2,
    parameter int CNT_W       = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic red,
    input  logic yellow,
    input  logic green,
    input  logic button,
    output logic walk,
    output logic dont_walk,
    output logic req_pending,
    output logic fault
);

    localparam int MAX_TICKS = (CLEAR_TICKS > WALK_TICKS)
                               ? ((CLEAR_TICKS > FLASH_HALF) ? CLEAR_TICKS : FLASH_HALF)
                               : ((WALK_TICKS > FLASH_HALF) ? WALK_TICKS : FLASH_HALF);
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    generate
        if (CLEAR_TICKS < 1 || WALK_TICKS < 1 || FLASH_HALF < 1 || MAX_TICKS > CNT_MAX) begin : g_param_check
            $error("peatonal: tick parameters must be >= 1 and fit in CNT_W bits");
        end
    endgenerate

    // The counter counts completed cycles in a phase; the phase ends on the edge
    // where it already holds TICKS-1, so each phase lasts exactly TICKS cycles.
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_TICKS - 1);
    localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(WALK_TICKS - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WALK,
        S_FLASH,
        S_FAULT
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               flash, flash_nxt;
    logic               req, req_nxt;
    logic               red_d;
    logic               button_d;
    logic               red_rise;
    logic               btn_rise;
    logic               conflict;

    // red_d resets to 1 so a red already lit at reset release is not a rising
    // edge: that red phase can never grant walk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            flash    <= 1'b0;
            req      <= 1'b0;
            red_d    <= 1'b1;
            button_d <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            flash    <= flash_nxt;
            req      <= req_nxt;
            red_d    <= red;
            button_d <= button;
        end
    end

    always_comb begin
        red_rise  = red & ~red_d;
        btn_rise  = button & ~button_d;
        // All-dark is legal and simply reads as "not red".
        conflict  = (red & yellow) | (red & green) | (yellow & green);

        state_nxt = state;
        cnt_nxt   = cnt;
        flash_nxt = flash;
        req_nxt   = req;

        // A press during WALK is already being served; FAULT freezes the request.
        if (btn_rise && (state == S_IDLE || state == S_CLEAR || state == S_FLASH)) begin
            req_nxt = 1'b1;
        end

        if (conflict) begin
            state_nxt = S_FAULT;
        end else begin
            case (state)
                S_IDLE: begin
                    // Only a red rising edge can start a crossing, so a request
                    // made mid-red waits for the next red phase.
                    if (red_rise && (req || btn_rise)) begin
                        state_nxt = S_CLEAR;
                        cnt_nxt   = '0;
                    end
                end
                S_CLEAR: begin
                    if (!red) begin
                        state_nxt = S_IDLE;
                    end else if (cnt == CLEAR_LAST) begin
                        state_nxt = S_WALK;
                        cnt_nxt   = '0;
                        req_nxt   = 1'b0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                S_WALK: begin
                    if (!red) begin
                        state_nxt = S_IDLE;
                    end else if (cnt == WALK_LAST) begin
                        state_nxt = S_FLASH;
                        cnt_nxt   = '0;
                        flash_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                S_FLASH: begin
                    if (!red) begin
                        state_nxt = S_IDLE;
                    end else if (cnt == FLASH_LAST) begin
                        cnt_nxt   = '0;
                        flash_nxt = ~flash;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                S_FAULT: begin
                    state_nxt = S_FAULT;
                end
                default: begin
                    state_nxt = S_FAULT;
                end
            endcase
        end
    end

    always_comb begin
        walk      = 1'b0;
        dont_walk = 1'b1;
        fault     = 1'b0;
        case (state)
            S_WALK: begin
                walk      = 1'b1;
                dont_walk = 1'b0;
            end
            S_FLASH: begin
                dont_walk = flash;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign req_pending = req;

endmodule

// File: tb/tb_peatonal.sv
// tb_peatonal: directed bench for the peatonal pedestrian controller.
// Each step drives the lamps/button, queues the expected outputs
// {walk, dont_walk, req_pending, fault} and compares them 1 ns after the edge.
module tb_peatonal;

    logic clk = 1'b0;
    logic rst;
    logic red;
    logic yellow;
    logic green;
    logic button;
    logic walk;
    logic dont_walk;
    logic req_pending;
    logic fault;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [3:0] exp_q[$];
    string      tag_q[$];

    peatonal #(
        .CLEAR_TICKS(2),
        .WALK_TICKS (8),
        .FLASH_HALF (2),
        .CNT_W      (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .red        (red),
        .yellow     (yellow),
        .green      (green),
        .button     (button),
        .walk       (walk),
        .dont_walk  (dont_walk),
        .req_pending(req_pending),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic compare_pop();
        logic [3:0] e;
        logic [3:0] obs;
        string      t;
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        obs = {walk, dont_walk, req_pending, fault};
        total_cnt = total_cnt + 1;
        assert (obs === e) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed w/dw/rp/f=%b expected %b", t, obs, e);
    endtask

    task automatic check_now(input logic [3:0] e, input string t);
        exp_q.push_back(e);
        tag_q.push_back(t);
        compare_pop();
    endtask

    task automatic step(input logic r, input logic y, input logic g, input logic b,
                        input logic [3:0] e, input string t);
        red    = r;
        yellow = y;
        green  = g;
        button = b;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(posedge clk);
        #1;
        compare_pop();
    endtask

    // Red held for n_edges edges starting with the rising edge; button high for
    // the first btn_n edges. Assumes a request is latched or pressed at e=0.
    task automatic red_phase(input int n_edges, input int btn_n, input string t);
        for (int e = 0; e < n_edges; e++) begin
            logic [3:0] ex;
            if (e < 2)       ex = 4'b0110;
            else if (e < 10) ex = 4'b1000;
            else             ex = ((((e - 10) / 2) % 2) == 0) ? 4'b0100 : 4'b0000;
            step(1'b1, 1'b0, 1'b0, (e < btn_n), ex, $sformatf("%s_e%0d", t, e));
        end
    endtask

    task automatic do_reset(input string t);
        red    = 1'b0;
        yellow = 1'b0;
        green  = 1'b1;
        button = 1'b0;
        rst    = 1'b0;
        #2;
        check_now(4'b0100, t);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst    = 1'b0;
        red    = 1'b1;
        yellow = 1'b0;
        green  = 1'b0;
        button = 1'b0;
        #1;
        check_now(4'b0100, "reset_state");
        @(posedge clk);
        #1;
        check_now(4'b0100, "reset_hold");
        rst = 1'b1;

        // Red already lit at reset release: request latches but never served.
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'b0110, "s1_btn");
        for (int i = 0; i < 19; i++)
            step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, $sformatf("s1_red%0d", i));
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0110, "s1_green");

        do_reset("s2_reset");

        // Button pulse in green, then a full 20-cycle red.
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, "s2_green");
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'b0110, "s2_btn");
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0110, "s2_wait");
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0110, "s2_yellow");
        red_phase(20, 0, "s2");
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, "s2_redfall");
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, "s2_idle");

        // Press on the same edge red rises, held for 10 cycles.
        red_phase(20, 10, "s3");
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, "s3_end");

        // Button held 10 cycles in green: exactly one request, served once.
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b0, 1'b1, 1'b1, 4'b0110, $sformatf("s3b_hold%0d", i));
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0110, "s3b_rel");
        red_phase(20, 0, "s3b");
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, "s3b_end");

        // Request made mid-red waits for the next red.
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, "s3c_red");
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'b0110, "s3c_midpress");
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, $sformatf("s3c_wait%0d", i));
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0110, "s3c_green");
        red_phase(20, 0, "s3c");
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, "s3c_end");

        // Red drops 4 cycles into WALK; press during WALK is ignored.
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'b0110, "s4_btn");
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, "s4_rise");
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, "s4_clear");
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, "s4_walk0");
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'b1000, "s4_walk1_btn");
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, "s4_walk2");
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, "s4_walk3");
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, "s4_abort");
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, "s4_idle");

        // Abort during CLEAR keeps the request.
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'b0110, "s4b_btn");
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, "s4b_rise");
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0110, "s4b_abort");

        // Lamp conflict during WALK latches FAULT until reset.
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, "s5_rise");
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, "s5_clear");
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, "s5_walk");
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'b0101, "s5_conflict");
        for (int i = 0; i < 30; i++)
            step((i % 3) == 2, (i % 3) == 1, (i % 3) == 0, (i % 4) == 0,
                 4'b0101, $sformatf("s5_hold%0d", i));
        red    = 1'b0;
        yellow = 1'b0;
        green  = 1'b1;
        button = 1'b0;
        rst    = 1'b0;
        #1;
        check_now(4'b0100, "s5_rst_clear");
        #2;
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, "s5_after");

        // Async reset mid-cycle while dont_walk is dark in FLASH.
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'b0110, "s6_btn");
        red_phase(13, 0, "s6");
        #3;
        rst = 1'b0;
        #1;
        check_now(4'b0100, "s6_async");
        #2;
        rst = 1'b1;
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, $sformatf("s6_red_held%0d", i));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/peatonal.md
Name: peatonal

Overview:
Pedestrian-crossing controller that sits directly downstream of the semaforo vehicle light. It consumes the red/yellow/green lamp outputs plus a pedestrian push-button, and drives the walk and dont_walk lamps. Walk is granted only inside a vehicle red phase, only if a request was latched, and only after a clearance delay. A lamp-conflict detector latches a safe fault state.

Parameters:
CLEAR_TICKS, 2, clock cycles after red rises before walk is lit (min 1)
WALK_TICKS, 8, clock cycles walk stays solid (min 1)
FLASH_HALF, 2, half-period in cycles of flashing dont_walk (min 1)
CNT_W, 5, phase counter width; must hold max(CLEAR_TICKS, WALK_TICKS, FLASH_HALF)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  asynchronous, active-low reset
red  in  1  vehicle red lamp from semaforo
yellow  in  1  vehicle yellow lamp from semaforo
green  in  1  vehicle green lamp from semaforo
button  in  1  pedestrian push-button, synchronous to clk, level
walk  out  1  walk lamp
dont_walk  out  1  don't-walk lamp
req_pending  out  1  request latched, not yet served
fault  out  1  lamp-conflict fault, sticky until reset

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, walk=0, dont_walk=1, req_pending=0, fault=0, red_d=1, button_d=0.
- red_d resetting to 1 means a red already active at reset release never grants walk.
- Inputs are sampled on posedge clk. Outputs are Moore, decoded from registered state/flash bit, and change only after an edge.
- red_rise = red & ~red_d. btn_rise = button & ~button_d. Holding button produces one request only.
- req_pending: set on btn_rise in IDLE, CLEAR or FLASH. Ignored in WALK. Cleared on the edge entering WALK.
- conflict = two or more of red/yellow/green high on the same edge. All-dark is not a conflict; it is treated as not red.
- IDLE: walk=0, dont_walk=1.
  - red_rise & (req_pending | btn_rise) -> CLEAR, counter=0. A press on the same edge as red_rise counts.
  - red_rise without a request: stay IDLE for this whole red. A request arriving mid-red waits for the next red.
- CLEAR: walk=0, dont_walk=1, counter++.
  - After CLEAR_TICKS cycles in CLEAR -> WALK, counter=0, req_pending cleared.
  - Walk is lit exactly CLEAR_TICKS cycles after the red_rise edge.
- WALK: walk=1, dont_walk=0.
  - After WALK_TICKS cycles -> FLASH, counter=0, flash bit=1.
- FLASH: walk=0, dont_walk=flash bit. The flash bit toggles every FLASH_HALF cycles, starting lit. Stay until red falls.
- red=0 in CLEAR, WALK or FLASH -> IDLE on that edge; dont_walk=1 next cycle. Early red termination aborts the walk, with no flash. req_pending is kept.
- conflict in any state -> FAULT on that edge (highest priority).
  - FAULT: walk=0, dont_walk=1, fault=1, req_pending held.
  - FAULT is left only by reset.
- Reset asserted mid-operation forces reset values immediately. Reset has priority over all.
- Counters never wrap in legal configurations. A parameter check fails elaboration if CNT_W is too small.

Test Plan:
- Reset release with red=1 and button pulsed once: red stays high 20 cycles -> walk never asserts, req_pending=1, dont_walk=1 throughout.
- Defaults, button pulse in green, then red high for 20 cycles:
  - req_pending=1 until walk rises.
  - walk rises 2 cycles after red_rise and stays high for 8 cycles.
  - dont_walk then follows 1,1,0,0,1,1… until red falls, then is solid 1.
- Button pressed on the same edge red rises -> identical timing to the previous case. Button held 10 cycles -> a single request only.
- Red drops 4 cycles into WALK -> walk=0 and dont_walk=1 the next cycle, state IDLE. Button pressed during WALK -> req_pending stays 0.
- red=1 and green=1 on one edge while in WALK:
  - fault=1, walk=0, dont_walk=1.
  - Stays in FAULT through 30 further cycles of legal lamps.
  - rst pulse low clears fault to 0.
- Async reset asserted mid-clock during FLASH -> outputs take reset values before the next posedge.
